// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win every cycle, load results queue
// in a small FIFO and retire in order on ALU-free cycles; younger ALU writes kill stale loads.
module regfile_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [REG_AW-1:0]            alu_reg,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [REG_AW-1:0]            mem_reg,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         RegWrite,
    output logic [REG_AW-1:0]            write_reg,
    output logic [DATA_W-1:0]            write_data,
    output logic [2**REG_AW-1:0]         busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [REG_AW-1:0] q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_live;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic push;
    logic pop;
    logic head_live;

    // Ready depends on registered occupancy only, so a full FIFO stays not-ready
    // even in a cycle where the head is popped.
    assign mem_ready  = (count != CW'(DEPTH));
    assign fifo_count = count;
    assign push       = mem_valid && mem_ready;
    assign pop        = !alu_valid && (count != '0);
    assign head_live  = q_live[rd_ptr];

    // NOTE: payload storage is deliberately left without reset; only the live bits and
    // pointers need a known value, and an unreset array maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= mem_reg;
            q_data[wr_ptr] <= mem_data;
        end
    end

    // NOTE: every sequential block uses non-blocking assignment, so later statements in
    // the same block (pop, push) override earlier ones (kill) for the same slot cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_live <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_valid && q_live[i] && (q_reg[i] == alu_reg))
                    q_live[i] <= 1'b0;
            end
            if (pop) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            // A load arriving alongside an ALU write to the same register is older, so it is dead on arrival.
            if (push) begin
                q_live[wr_ptr] <= !(alu_valid && (mem_reg == alu_reg));
                wr_ptr         <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: default assigned first so no path through the loop can infer a latch.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i])
                busy_mask[q_reg[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (alu_valid) begin
            RegWrite   <= 1'b1;
            write_reg  <= alu_reg;
            write_data <= alu_data;
        end else if (pop) begin
            RegWrite <= head_live;
            if (head_live) begin
                write_reg  <= q_reg[rd_ptr];
                write_data <= q_data[rd_ptr];
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: stimulus queues expected writes,
// a negedge monitor compares every RegWrite against the queue head.
module tb_regfile_writeback_arbiter;

    typedef struct {
        logic [2:0]  r;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [2:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_reg;
    logic [31:0] mem_data;
    logic        RegWrite;
    logic [2:0]  write_reg;
    logic [31:0] write_data;
    logic [7:0]  busy_mask;
    logic [2:0]  fifo_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    regfile_writeback_arbiter #(.DATA_W(32), .REG_AW(3), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .busy_mask(busy_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic set_alu(input logic v, input logic [2:0] r, input logic [31:0] d);
        exp_t e;
        alu_valid = v;
        alu_reg   = r;
        alu_data  = d;
        if (v) begin
            e.r = r;
            e.d = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_mem(input logic v, input logic [2:0] r, input logic [31:0] d);
        mem_valid = v;
        mem_reg   = r;
        mem_data  = d;
    endtask

    task automatic expect_load(input logic [2:0] r, input logic [31:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register write must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                             write_reg, write_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_reg", 32'(write_reg), 32'(e.r));
                    check("wb_data", write_data, e.d);
                end
            end
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_regwrite", 32'(RegWrite), 0);
        check("rst_write_data", write_data, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_regwrite", 32'(RegWrite), 0);
        check("idle_mem_ready", 32'(mem_ready), 1);
        check("idle_count", 32'(fifo_count), 0);
        check("idle_busy", 32'(busy_mask), 0);

        // Single ALU write
        set_alu(1'b1, 3'd3, 32'h11);
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        check("alu_regwrite", 32'(RegWrite), 1);

        // Load queued behind three ALU cycles
        set_alu(1'b1, 3'd1, 32'h101);
        set_mem(1'b1, 3'd5, 32'hAA);
        @(negedge clk);
        check("ld_busy0", 32'(busy_mask), 32'h20);
        check("ld_count", 32'(fifo_count), 1);
        set_mem(1'b0, '0, '0);
        set_alu(1'b1, 3'd4, 32'h104);
        @(negedge clk);
        check("ld_busy1", 32'(busy_mask), 32'h20);
        set_alu(1'b1, 3'd6, 32'h106);
        @(negedge clk);
        check("ld_busy2", 32'(busy_mask), 32'h20);
        expect_load(3'd5, 32'hAA);
        set_alu(1'b0, '0, '0);
        @(negedge clk);
        check("ld_busy_clear", 32'(busy_mask), 0);
        check("ld_count_clear", 32'(fifo_count), 0);

        // Fill FIFO while ALU is busy, hold a fifth load
        for (int k = 0; k < 4; k++) begin
            set_alu(1'b1, 3'd0, 32'h200 + k);
            set_mem(1'b1, 3'(k + 1), 32'h40 + k);
            @(negedge clk);
        end
        check("full_ready", 32'(mem_ready), 0);
        check("full_count", 32'(fifo_count), 4);
        check("full_busy", 32'(busy_mask), 32'h1E);
        set_mem(1'b1, 3'd7, 32'h77);
        set_alu(1'b1, 3'd0, 32'h210);
        @(negedge clk);
        check("held_ready", 32'(mem_ready), 0);
        check("held_count", 32'(fifo_count), 4);
        set_alu(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) expect_load(3'(k + 1), 32'h40 + k);
        expect_load(3'd7, 32'h77);
        @(negedge clk);
        check("pop_count", 32'(fifo_count), 3);
        check("pop_ready", 32'(mem_ready), 1);
        @(negedge clk);
        check("pushpop_count", 32'(fifo_count), 3);
        set_mem(1'b0, '0, '0);
        waited = 0;
        while (fifo_count != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", 32'(fifo_count), 0);
        check("drain_busy", 32'(busy_mask), 0);

        // WAW kill of a queued load
        set_mem(1'b1, 3'd2, 32'h22);
        @(negedge clk);
        check("waw_busy_set", 32'(busy_mask), 32'h04);
        set_mem(1'b0, '0, '0);
        set_alu(1'b1, 3'd2, 32'h99);
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        check("waw_busy_clear", 32'(busy_mask), 0);
        check("waw_count", 32'(fifo_count), 1);
        @(negedge clk);
        check("killed_regwrite", 32'(RegWrite), 0);
        check("killed_hold_reg", 32'(write_reg), 2);
        check("killed_hold_data", write_data, 32'h99);
        check("killed_count", 32'(fifo_count), 0);

        // Same-cycle push and ALU write to the same register
        set_alu(1'b1, 3'd6, 32'h66);
        set_mem(1'b1, 3'd6, 32'h60);
        @(negedge clk);
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        check("same_busy", 32'(busy_mask), 0);
        check("same_count", 32'(fifo_count), 1);
        @(negedge clk);
        check("same_regwrite", 32'(RegWrite), 0);
        check("same_hold_data", write_data, 32'h66);
        check("same_count_after", 32'(fifo_count), 0);

        // Reset mid-stream discards queued loads
        for (int k = 0; k < 3; k++) begin
            set_alu(1'b1, 3'd0, 32'h300 + k);
            set_mem(1'b1, 3'(k + 1), 32'h50 + k);
            @(negedge clk);
        end
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        check("pre_rst_count", 32'(fifo_count), 3);
        check("pre_rst_busy", 32'(busy_mask), 32'h0E);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_regwrite", 32'(RegWrite), 0);
        check("mid_rst_reg", 32'(write_reg), 0);
        check("mid_rst_data", write_data, 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_busy", 32'(busy_mask), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_count", 32'(fifo_count), 0);
        check("post_rst_regwrite", 32'(RegWrite), 0);
        check("post_rst_busy", 32'(busy_mask), 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
